// File: rtl/crc4fsk_frame_tx_pkg.sv
// crc4fsk_pkg: shared types and constants for the CRC-framed 4FSK transmitter
// (and its receiver counterpart).
package crc4fsk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CRC,
        PRE,
        SEND,
        DONE
    } state_t;

    // Frequency words for the four tones, indexed by Gray position.
    localparam logic [15:0] FSK_FREQ [0:3] = '{16'h1200, 16'h1600, 16'h1A00, 16'h1E00};

    // x^4 + x + 1, top term implicit.
    localparam logic [3:0] CRC4_POLY_DEFAULT = 4'b0011;
    localparam logic [3:0] CRC4_INIT_DEFAULT = 4'h0;

    // Gray symbol to tone index: 00->0, 01->1, 11->2, 10->3.
    function automatic logic [1:0] gray_to_idx(input logic [1:0] s);
        logic [1:0] idx;
        case (s)
            2'b00:   idx = 2'd0;
            2'b01:   idx = 2'd1;
            2'b11:   idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/crc4fsk_frame_tx_crc_serial.sv
// crc_serial: one-bit-per-cycle MSB-first CRC LFSR, no reflection, no final XOR.
// o_crc_nxt exposes the value the register takes on the next enabled edge.
module crc_serial
    import crc4fsk_pkg::*;
#(
    parameter int unsigned    W    = 4,
    parameter logic [W-1:0]   POLY = CRC4_POLY_DEFAULT,
    parameter logic [W-1:0]   INIT = CRC4_INIT_DEFAULT
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic         i_en,
    input  logic         i_bit,
    output logic [W-1:0] o_crc,
    output logic [W-1:0] o_crc_nxt
);

    logic [W-1:0] r_crc;
    logic         w_fb;

    // Feedback and next-state of the LFSR.
    always_comb begin
        w_fb      = i_bit ^ r_crc[W-1];
        o_crc_nxt = {r_crc[W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    end

    // CRC register: load has priority over shift.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_crc <= '0;
        else if (i_load)
            r_crc <= INIT;
        else if (i_en)
            r_crc <= o_crc_nxt;
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/crc4fsk_frame_tx.sv
// crc4fsk_frame_tx: latches a word on `next`, computes its CRC serially, then
// sends {data, crc} as 2-bit Gray-mapped 4FSK symbols of SYM_CYC cycles each.
// Optional preamble (00,11,00,...) before the data: define CRC4FSK_PREAMBLE_EN.
module crc4fsk_frame_tx
    import crc4fsk_pkg::*;
#(
    parameter int unsigned      DATA_W   = 8,
    parameter int unsigned      CRC_W    = 4,
    parameter logic [CRC_W-1:0] CRC_POLY = CRC4_POLY_DEFAULT,
    parameter logic [CRC_W-1:0] CRC_INIT = CRC4_INIT_DEFAULT,
    parameter int unsigned      SYM_CYC  = 3200,
    parameter int unsigned      FREQ_W   = 16,
    parameter int unsigned      PRE_SYM  = 4
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              next,
    input  logic [DATA_W-1:0] inputdata,
    output logic              busy,
    output logic              sym_valid,
    output logic [1:0]        sym,
    output logic [FREQ_W-1:0] freq_word,
    output logic [CRC_W-1:0]  crc_out,
    output logic              frame_done
);

    localparam int unsigned FRAME_W = DATA_W + CRC_W;
    localparam int unsigned N_SYM   = FRAME_W / 2;
    localparam int unsigned CYC_W   = (SYM_CYC > 1) ? $clog2(SYM_CYC) : 1;
    localparam int unsigned BIT_W   = $clog2(DATA_W);
    localparam int unsigned IDX_W   = $clog2(N_SYM + PRE_SYM + 1);
`ifdef CRC4FSK_PREAMBLE_EN
    localparam state_t      POST_CRC = PRE;
`else
    localparam state_t      POST_CRC = SEND;
`endif

    state_t              r_state, w_next_state;
    logic [DATA_W-1:0]   r_data;
    logic [FRAME_W-1:0]  r_shift;
    logic [BIT_W-1:0]    r_bitcnt;
    logic [CYC_W-1:0]    r_cyc;
    logic [IDX_W-1:0]    r_symidx;
    logic [CRC_W-1:0]    w_crc, w_crc_nxt;
    logic [BIT_W-1:0]    w_bit_idx;
    logic                w_accept, w_crc_last, w_sym_end, w_pre_last, w_send_last;

    assign w_accept    = (r_state == IDLE) && next;
    assign w_crc_last  = (r_state == CRC) && (r_bitcnt == BIT_W'(DATA_W - 1));
    assign w_sym_end   = (r_cyc == CYC_W'(SYM_CYC - 1));
    assign w_send_last = (r_state == SEND) && w_sym_end && (r_symidx == IDX_W'(N_SYM - 1));
`ifdef CRC4FSK_PREAMBLE_EN
    assign w_pre_last  = (r_state == PRE) && w_sym_end && (r_symidx == IDX_W'(PRE_SYM - 1));
`else
    assign w_pre_last  = 1'b0;
`endif
    assign w_bit_idx   = BIT_W'(DATA_W - 1) - r_bitcnt;

    crc_serial #(
        .W    (CRC_W),
        .POLY (CRC_POLY),
        .INIT (CRC_INIT)
    ) u_crc (
        .i_clk     (sys_clk),
        .i_rst_n   (reset),
        .i_load    (w_accept),
        .i_en      (r_state == CRC),
        .i_bit     (r_data[w_bit_idx]),
        .o_crc     (w_crc),
        .o_crc_nxt (w_crc_nxt)
    );

    // State register.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    // Next-state and output decode.
    always_comb begin
        w_next_state = r_state;
        busy         = (r_state != IDLE);
        sym_valid    = 1'b0;
        sym          = 2'b00;
        freq_word    = '0;
        frame_done   = 1'b0;
        case (r_state)
            IDLE: if (next) w_next_state = CRC;
            CRC:  if (w_crc_last) w_next_state = POST_CRC;
`ifdef CRC4FSK_PREAMBLE_EN
            PRE: begin
                sym_valid = 1'b1;
                sym       = r_symidx[0] ? 2'b11 : 2'b00;
                if (w_pre_last) w_next_state = SEND;
            end
`endif
            SEND: begin
                sym_valid = 1'b1;
                sym       = r_shift[FRAME_W-1 -: 2];
                if (w_send_last) w_next_state = DONE;
            end
            DONE: begin
                frame_done   = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
        if (sym_valid)
            freq_word = FREQ_W'(FSK_FREQ[gray_to_idx(sym)]);
    end

    // The CRC register holds the frame CRC once CRC ends; it is masked while
    // being recomputed so crc_out reads 0 from acceptance until the first symbol.
    assign crc_out = (r_state == CRC) ? '0 : w_crc;

    // Datapath: data latch, bit counter, symbol timer and frame shift register.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_data   <= '0;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_cyc    <= '0;
            r_symidx <= '0;
        end else begin
            if (w_accept) begin
                r_data   <= inputdata;
                r_bitcnt <= '0;
                r_cyc    <= '0;
                r_symidx <= '0;
            end
            if (r_state == CRC) begin
                r_bitcnt <= r_bitcnt + BIT_W'(1);
                if (w_crc_last)
                    r_shift <= {r_data, w_crc_nxt};
            end
            if ((r_state == PRE) || (r_state == SEND)) begin
                r_cyc <= w_sym_end ? '0 : r_cyc + CYC_W'(1);
                if (w_sym_end) begin
                    r_symidx <= w_pre_last ? '0 : r_symidx + IDX_W'(1);
                    if (r_state == SEND)
                        r_shift <= {r_shift[FRAME_W-3:0], 2'b00};
                end
            end
        end
    end

endmodule

// File: tb/tb_crc4fsk_frame_tx.sv
// Testbench for crc4fsk_frame_tx (short SYM_CYC to keep frames small).
// Follows CRC4FSK_PREAMBLE_EN if defined at compile time.
module tb_crc4fsk_frame_tx;

    localparam int SC = 13;
`ifdef CRC4FSK_PREAMBLE_EN
    localparam int PRE = 4;
`else
    localparam int PRE = 0;
`endif
    localparam int NS   = PRE + 6;
    localparam int LAST = 8 + NS * SC;   // last symbol cycle, relative to acceptance edge

    logic        sys_clk = 1'b0;
    logic        reset, next;
    logic [7:0]  inputdata;
    logic        busy, sym_valid, frame_done;
    logic [1:0]  sym;
    logic [15:0] freq_word;
    logic [3:0]  crc_out;

    int n_cmp = 0;
    int n_err = 0;

    crc4fsk_frame_tx #(
        .DATA_W  (8),
        .CRC_W   (4),
        .SYM_CYC (SC),
        .FREQ_W  (16),
        .PRE_SYM (4)
    ) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .next       (next),
        .inputdata  (inputdata),
        .busy       (busy),
        .sym_valid  (sym_valid),
        .sym        (sym),
        .freq_word  (freq_word),
        .crc_out    (crc_out),
        .frame_done (frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] fsk(input logic [1:0] s);
        case (s)
            2'b00:   return 16'h1200;
            2'b01:   return 16'h1600;
            2'b11:   return 16'h1A00;
            default: return 16'h1E00;
        endcase
    endfunction

    // Expected {busy, sym_valid, sym, freq_word, frame_done, crc_out} in cycle t+k.
    function automatic logic [24:0] exp_vec(input int k, input logic [11:0] syms, input logic [3:0] c);
        int         i;
        logic [1:0] s;
        if (k <= 8)
            return {1'b1, 1'b0, 2'b00, 16'h0, 1'b0, 4'h0};
        else if (k <= LAST) begin
            i = (k - 9) / SC;
            if (i < PRE)
                s = (i % 2 == 1) ? 2'b11 : 2'b00;
            else
                s = syms[11 - 2*(i-PRE) -: 2];
            return {1'b1, 1'b1, s, fsk(s), 1'b0, c};
        end else if (k == LAST + 1)
            return {1'b1, 1'b0, 2'b00, 16'h0, 1'b1, c};
        else
            return {1'b0, 1'b0, 2'b00, 16'h0, 1'b0, c};
    endfunction

    function automatic logic [24:0] obs();
        return {busy, sym_valid, sym, freq_word, frame_done, crc_out};
    endfunction

    // One frame from IDLE; optionally pulse next mid-SEND (must be ignored).
    task automatic run_frame(input string name, input logic [7:0] d, input logic [11:0] syms,
                             input logic [3:0] c, input bit poke);
        int poke_k;
        poke_k = 8 + PRE*SC + 2*SC + 2;
        @(negedge sys_clk);
        inputdata = d;
        next      = 1'b1;
        @(posedge sys_clk);
        #1;
        next      = 1'b0;
        inputdata = ~d;
        for (int k = 1; k <= LAST + 3; k++) begin
            if (k > 1) begin
                @(posedge sys_clk);
                #1;
            end
            if (poke) next = (k == poke_k);
            check_eq($sformatf("%s k=%0d", name, k), 32'(obs()), 32'(exp_vec(k, syms, c)));
        end
        next = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        next      = 1'b1;
        inputdata = 8'h80;
        // Reset held with next=1: everything stays 0.
        repeat (5) begin
            @(negedge sys_clk);
            check_eq("rst_hold", 32'(obs()), 32'h0);
        end
        next  = 1'b0;
        reset = 1'b1;
        @(negedge sys_clk);
        check_eq("idle", 32'(obs()), 32'h0);

        run_frame("d00", 8'h00, 12'h000, 4'h0, 1'b0);
        run_frame("d80", 8'h80, 12'h80E, 4'hE, 1'b0);
        run_frame("dA5", 8'hA5, 12'hA5B, 4'hB, 1'b0);
        run_frame("d80poke", 8'h80, 12'h80E, 4'hE, 1'b1);

        // next held high: two frames back-to-back with one IDLE cycle between.
        @(negedge sys_clk);
        inputdata = 8'hA5;
        next      = 1'b1;
        @(posedge sys_clk);
        #1;
        for (int k = 1; k <= 2*LAST + 5; k++) begin
            if (k > 1) begin
                @(posedge sys_clk);
                #1;
            end
            if (k == LAST + 3) next = 1'b0;
            if (k <= LAST + 2)
                check_eq($sformatf("b2b k=%0d", k), 32'(obs()), 32'(exp_vec(k, 12'hA5B, 4'hB)));
            else
                check_eq($sformatf("b2b k=%0d", k), 32'(obs()),
                         32'(exp_vec(k - (LAST + 2), 12'hA5B, 4'hB)));
        end

        // Reset during the third data symbol aborts asynchronously.
        @(negedge sys_clk);
        inputdata = 8'h80;
        next      = 1'b1;
        @(posedge sys_clk);
        #1;
        next = 1'b0;
        for (int k = 1; k <= 8 + PRE*SC + 2*SC + 4; k++) begin
            if (k > 1) begin
                @(posedge sys_clk);
                #1;
            end
            check_eq($sformatf("pre_abort k=%0d", k), 32'(obs()), 32'(exp_vec(k, 12'h80E, 4'hE)));
        end
        #1;
        reset = 1'b0;
        #1;
        check_eq("abort_async", 32'(obs()), 32'h0);
        @(negedge sys_clk);
        check_eq("abort_hold", 32'(obs()), 32'h0);
        reset = 1'b1;
        @(negedge sys_clk);
        check_eq("abort_idle", 32'(obs()), 32'h0);
        run_frame("after_abort", 8'hA5, 12'hA5B, 4'hB, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/crc4fsk_frame_tx.md
# crc4fsk_frame_tx

Parametrised CRC-framed 4FSK transmitter. A `next` pulse latches a DATA_W-bit word, computes a CRC_W-bit CRC serially, and emits the data word followed by its CRC as 2-bit symbols. Each symbol is held for SYM_CYC cycles together with its 4FSK frequency word. It is the next-generation transmit half of the CRC/4FSK byte loopback, generalised in word width, CRC polynomial and symbol rate, and it adds busy, done and preamble behaviour.

## Interface
- DATA_W, 8: payload width. Must be ≥2.
- CRC_W, 4: CRC width. DATA_W+CRC_W must be even.
- CRC_POLY, 4'b0011: generator polynomial without the top term (x^4+x+1).
- CRC_INIT, 0: CRC register value at frame start.
- SYM_CYC, 3200: clock cycles per symbol. Must be ≥1.
- FREQ_W, 16: frequency-word width.
- PRE_SYM, 4: preamble length in symbols. Used only with CRC4FSK_PREAMBLE_EN.

Ports:
- sys_clk  in  1  system clock. All logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- next  in  1  start pulse. Sampled only in IDLE.
- inputdata  in  DATA_W  payload. Latched on the accepted `next`.
- busy  out  1  high from the cycle after acceptance until frame_done inclusive.
- sym_valid  out  1  high while a symbol is on air.
- sym  out  2  current symbol.
- freq_word  out  FREQ_W  FSK_FREQ[sym] when sym_valid, else 0.
- crc_out  out  CRC_W  CRC of the last frame. Valid from the first data symbol; held until the next acceptance.
- frame_done  out  1  one-cycle pulse at end of frame.

## Operation
- States: IDLE → CRC → (PRE) → SEND → DONE → IDLE.
- IDLE: next=1 latches inputdata, loads the CRC register with CRC_INIT, and clears crc_out and the bit counter.
- CRC: lasts DATA_W cycles, MSB first, one data bit per cycle.
  - fb = bit ^ crc[CRC_W-1]
  - crc = {crc[CRC_W-2:0],0} ^ (fb ? CRC_POLY : 0)
  - No reflection, no final XOR.
- SEND: the shift register holds {data, crc}, MSB first, with (DATA_W+CRC_W)/2 symbols.
  - sym = top two bits.
  - A 2-bit shift occurs every SYM_CYC cycles.
- Symbol mapping is Gray: 00→FSK_FREQ[0], 01→[1], 11→[2], 10→[3].
- DONE: lasts one cycle, with frame_done=1 and sym_valid=0. IDLE follows.
- next asserted outside IDLE is ignored, not queued.
- next held high continuously restarts a frame in each IDLE cycle, so frames run back-to-back with one IDLE cycle between them.
- Reset mid-frame aborts immediately. All outputs go to 0 and the state goes to IDLE.
- Reset value of every output: 0.

## Timing
- Accepted next at edge t:
  - busy=1 from t+1.
  - CRC occupies cycles t+1..t+DATA_W.
  - The first symbol (or preamble) starts at t+DATA_W+1.
- Each symbol occupies exactly SYM_CYC consecutive cycles. There are no gaps between symbols.
- frame_done occurs in the cycle after the last symbol cycle. busy drops in the following cycle.
- Total frame time with defaults: 8 + 6×3200 + 1 = 19209 cycles.
- The symbol counter width is $clog2(SYM_CYC). The counter wraps to 0 on each symbol boundary.

## Configuration
- CRC4FSK_PREAMBLE_EN defined:
  - A PRE state sends PRE_SYM symbols alternating 00,11,00,… between CRC and SEND.
  - All SEND timing shifts by PRE_SYM×SYM_CYC.
  - busy and sym_valid cover the preamble.
- CRC4FSK_PREAMBLE_EN undefined: there is no PRE state and CRC goes directly to SEND.

## Structure
- Package crc4fsk_pkg holds:
  - state enum {IDLE, CRC, PRE, SEND, DONE};
  - FSK_FREQ[0:3] frequency constants;
  - the Gray-map function;
  - the defaults for CRC_POLY and CRC_INIT.
- Sub-module crc_serial is a parametrised one-bit-per-cycle LFSR with load, enable, bit input and crc output. It is reused by the receiver.

## Test plan
- Reset held low with next=1 → all outputs stay 0 and busy never rises.
- inputdata=8'h00 → crc_out=4'h0, six symbols 00, freq_word=FSK_FREQ[0] for 19200 cycles, then frame_done at t+19209.
- inputdata=8'h80 → crc_out=4'hE, symbols 10,00,00,00,11,10, with freq_word at [3],[0],[0],[0],[2],[3].
- next pulsed again during SEND for 8'h80 → ignored. The frame is identical and exactly one frame_done occurs.
- Reset asserted at the third symbol → outputs 0 within the same cycle (asynchronous). A next after release sends a full, correct frame.
- With CRC4FSK_PREAMBLE_EN and PRE_SYM=4, send 8'h00 → preamble symbols 00,11,00,11, then six 00 symbols. frame_done at t+8+10×SYM_CYC+1.
